sysbus_arbiter: RTL and testbench
=================================

Name: sysbus_arbiter

Overview:
- Two-requester arbiter sharing the single Sysbus master port between instruction fetch (port 0) and data memory (port 1).
- Grants bus ownership for one complete transaction:
  - a read is one request beat plus BEATS response beats;
  - a write is one address beat plus BEATS data beats.
- Forwards request signals to the bus and steers response beats back to the owner.
- Sits between the core front end / LSU and the top-level bus pins.

Parameters:
- BUS_DATA_WIDTH, 64, width of req/resp data.
- BUS_TAG_WIDTH, 13, width of req/resp tag.
- BEATS, 8, data beats per transaction (one 64-byte line).
- WR_CODE, 4'h1, value of reqtag[11:8] identifying a write; any other value is a read.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_reqcyc  in  1  port 0 request valid
- m0_req  in  BUS_DATA_WIDTH  port 0 address/data beat
- m0_reqtag  in  BUS_TAG_WIDTH  port 0 request tag
- m0_reqack  out  1  port 0 beat accepted
- m0_respcyc  out  1  port 0 response valid
- m0_resp  out  BUS_DATA_WIDTH  port 0 response data
- m0_resptag  out  BUS_TAG_WIDTH  port 0 response tag
- m0_respack  in  1  port 0 response beat consumed
- m1_* (same 8 signals)  port 1, identical directions and widths
- bus_reqcyc  out  1  to Sysbus
- bus_req  out  BUS_DATA_WIDTH  to Sysbus
- bus_reqtag  out  BUS_TAG_WIDTH  to Sysbus
- bus_reqack  in  1  from Sysbus
- bus_respcyc  in  1  from Sysbus
- bus_resp  in  BUS_DATA_WIDTH  from Sysbus
- bus_resptag  in  BUS_TAG_WIDTH  from Sysbus
- bus_respack  out  1  to Sysbus

Behaviour:
- Clocking: clk; reset synchronous, active-high.
- Registered state:
  - state: IDLE, REQ, RESP.
  - grant: 1 bit, owning port.
  - last: 1 bit, round-robin pointer.
  - is_wr: latched write flag.
  - beat_cnt: $clog2(BEATS+2) bits.
- Reset values: state=IDLE, grant=0, last=1 (so port 0 wins the first tie), beat_cnt=0, is_wr=0.
  - All outputs are 0 in IDLE, including at reset. Outputs are combinational from state/grant.
- IDLE:
  - No bus signals are driven.
  - If any mN_reqcyc=1: winner = sole requester, or ~last if both request. Register grant=winner, last=winner, is_wr=(winner reqtag[11:8]==WR_CODE), beat_cnt=0, state→REQ.
  - Arbitration latency is exactly 1 cycle; no reqack is given in IDLE.
- REQ:
  - bus_reqcyc/req/reqtag = granted port's signals.
  - m[grant]_reqack = bus_reqack; the other port's reqack = 0.
  - A beat is accepted when bus_reqcyc & bus_reqack; beat_cnt increments.
  - Read: first accepted beat → RESP, beat_cnt=0.
  - Write: accepted beat number BEATS+1 → IDLE.
  - Owner drops reqcyc with beat_cnt==0 → IDLE (abandoned; nothing was sent).
  - Owner drops reqcyc mid-write: grant is held and waits; this is not an error.
- RESP:
  - m[grant]_respcyc = bus_respcyc; m[grant]_resp/resptag = bus_resp/bus_resptag. The non-owner sees respcyc=0 and resp/resptag=0.
  - bus_respack = m[grant]_respack.
  - Each cycle with bus_respcyc & bus_respack increments beat_cnt.
  - Beat BEATS → IDLE.
  - bus_reqcyc=0 throughout RESP; the non-owner stalls.
- Back-to-back: returning to IDLE costs 1 idle cycle before the next grant.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1.
- A request arriving at the other port during REQ/RESP is held off (reqack=0) until the next IDLE.
- Reset mid-transaction: next edge forces IDLE. Outputs drop in the same cycle the reset edge lands. In-flight bus beats are dropped; the bus owner is responsible for retry.
- Simultaneous bus_reqack and bus_respcyc in REQ: bus_respcyc is ignored until RESP.
- beat_cnt never wraps: it is cleared on every state entry.

Optional Feature:
- Macro: SYSBUS_ARB_DPRIO_EN.
- Defined: fixed priority. Port 1 (data) wins every tie in IDLE and `last` is unused. Port 0 is granted only when port 1 is idle.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Port 0 read only, addr 0x1000, tag 0x1100; bus acks the request in 2 cycles, then returns 8 beats 0xA0..0xA7 with respack always 1 → m0_reqack pulses once; m0 receives all 8 beats in order with tag intact; m1_respcyc stays 0; IDLE reached after beat 8.
- Both ports request reads in the same cycle after reset → port 0 granted first; port 1 granted on the first IDLE→REQ after port 0's 8th response beat, with 1 idle cycle between. With SYSBUS_ARB_DPRIO_EN, port 1 is granted first.
- Port 1 write, tag[11:8]=WR_CODE, 9 beats 0x2000, D0..D7 → bus sees all 9 beats in order; return to IDLE with no RESP state; a port 0 request pending meanwhile gets reqack=0 until then.
- Continuous requests on both ports for 4 transactions → grant sequence 0,1,0,1 (round-robin build).
- Reset asserted during RESP after beat 3 → next cycle all outputs 0, state=IDLE; a fresh port 1 read completes normally.
- Owner m0 drops reqcyc before the first reqack → returns to IDLE; a pending m1 request is granted on the next cycle.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// Two-port Sysbus arbiter: instruction fetch (port 0) and data memory (port 1) share one master port.
// Build option SYSBUS_ARB_DPRIO_EN: port 1 wins every tie (fixed priority) instead of round-robin.
module sysbus_arbiter #(
  parameter int         BUS_DATA_WIDTH = 64,
  parameter int         BUS_TAG_WIDTH  = 13,
  parameter int         BEATS          = 8,
  parameter logic [3:0] WR_CODE        = 4'h1
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      m0_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
  output logic                      m0_reqack,
  output logic                      m0_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
  input  logic                      m0_respack,

  input  logic                      m1_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
  output logic                      m1_reqack,
  output logic                      m1_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
  input  logic                      m1_respack,

  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int CNT_W = $clog2(BEATS + 2);
  localparam logic [CNT_W-1:0] LAST_WR_CNT   = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_RESP_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_grant;
  logic             r_is_wr;
  logic [CNT_W-1:0] r_beat_cnt;

  logic w_winner;
  logic w_win_wr;
  logic w_own_reqcyc;
  logic w_own_respack;
  logic w_req_fire;
  logic w_resp_fire;

`ifdef SYSBUS_ARB_DPRIO_EN
  assign w_winner = m1_reqcyc;
`else
  logic r_last;

  // On a tie the port that did not win last time goes next.
  assign w_winner = (m0_reqcyc && m1_reqcyc) ? ~r_last : m1_reqcyc;
`endif

  assign w_win_wr      = w_winner ? (m1_reqtag[11:8] == WR_CODE)
                                  : (m0_reqtag[11:8] == WR_CODE);
  assign w_own_reqcyc  = r_grant ? m1_reqcyc  : m0_reqcyc;
  assign w_own_respack = r_grant ? m1_respack : m0_respack;
  assign w_req_fire    = (r_state == S_REQ)  && w_own_reqcyc && bus_reqack;
  assign w_resp_fire   = (r_state == S_RESP) && bus_respcyc  && w_own_respack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= 1'b0;
      r_is_wr    <= 1'b0;
      r_beat_cnt <= '0;
`ifndef SYSBUS_ARB_DPRIO_EN
      r_last     <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_reqcyc || m1_reqcyc) begin
            r_state    <= S_REQ;
            r_grant    <= w_winner;
            r_is_wr    <= w_win_wr;
            r_beat_cnt <= '0;
`ifndef SYSBUS_ARB_DPRIO_EN
            r_last     <= w_winner;
`endif
          end
        end

        S_REQ: begin
          if (w_req_fire) begin
            if (!r_is_wr) begin
              r_state    <= S_RESP;
              r_beat_cnt <= '0;
            end else if (r_beat_cnt == LAST_WR_CNT) begin
              r_state    <= S_IDLE;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end else if (!w_own_reqcyc && (r_beat_cnt == '0)) begin
            // Owner withdrew before anything reached the bus: release the grant.
            r_state <= S_IDLE;
          end
        end

        S_RESP: begin
          if (w_resp_fire) begin
            if (r_beat_cnt == LAST_RESP_CNT) begin
              r_state    <= S_IDLE;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  // Request and response steering depend only on state and owner.
  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    m0_reqack   = 1'b0;
    m1_reqack   = 1'b0;
    m0_respcyc  = 1'b0;
    m1_respcyc  = 1'b0;
    m0_resp     = '0;
    m1_resp     = '0;
    m0_resptag  = '0;
    m1_resptag  = '0;
    case (r_state)
      S_REQ: begin
        bus_reqcyc = w_own_reqcyc;
        bus_req    = r_grant ? m1_req    : m0_req;
        bus_reqtag = r_grant ? m1_reqtag : m0_reqtag;
        m0_reqack  = ~r_grant & bus_reqack;
        m1_reqack  =  r_grant & bus_reqack;
      end
      S_RESP: begin
        bus_respack = w_own_respack;
        if (r_grant) begin
          m1_respcyc = bus_respcyc;
          m1_resp    = bus_resp;
          m1_resptag = bus_resptag;
        end else begin
          m0_respcyc = bus_respcyc;
          m0_resp    = bus_resp;
          m0_resptag = bus_resptag;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: transaction-level reference model checked every cycle, directed scenarios, random traffic.
`timescale 1ns/1ps
module tb_sysbus_arbiter;
  localparam int         BEATS   = 8;
  localparam logic [3:0] WR_CODE = 4'h1;
`ifdef SYSBUS_ARB_DPRIO_EN
  localparam bit DPRIO = 1'b1;
`else
  localparam bit DPRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_reqcyc, m0_reqack, m0_respcyc, m0_respack;
  logic [63:0] m0_req, m0_resp;
  logic [12:0] m0_reqtag, m0_resptag;
  logic        m1_reqcyc, m1_reqack, m1_respcyc, m1_respack;
  logic [63:0] m1_req, m1_resp;
  logic [12:0] m1_reqtag, m1_resptag;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;

  always #5 clk = ~clk;

  sysbus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_reqcyc(m0_reqcyc), .m0_req(m0_req), .m0_reqtag(m0_reqtag), .m0_reqack(m0_reqack),
    .m0_respcyc(m0_respcyc), .m0_resp(m0_resp), .m0_resptag(m0_resptag), .m0_respack(m0_respack),
    .m1_reqcyc(m1_reqcyc), .m1_req(m1_req), .m1_reqtag(m1_reqtag), .m1_reqack(m1_reqack),
    .m1_respcyc(m1_respcyc), .m1_resp(m1_resp), .m1_resptag(m1_resptag), .m1_respack(m1_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pcyc(int p);         return (p == 1) ? m1_reqcyc  : m0_reqcyc;  endfunction
  function automatic logic [63:0] preq(int p);  return (p == 1) ? m1_req     : m0_req;     endfunction
  function automatic logic [12:0] ptag(int p);  return (p == 1) ? m1_reqtag  : m0_reqtag;  endfunction
  function automatic logic pack(int p);         return (p == 1) ? m1_reqack  : m0_reqack;  endfunction
  function automatic logic prack(int p);        return (p == 1) ? m1_respack : m0_respack; endfunction

  // Reference model: who owns the bus and how many beats moved each way.
  int mdl_owner = -1;
  int mdl_sent  = 0;
  int mdl_recv  = 0;
  bit mdl_wr    = 1'b0;
  bit mdl_last  = 1'b1;
  bit mdl_ok    = 1'b0;

  function automatic bit in_req();  return (mdl_owner >= 0) && (mdl_wr || mdl_sent == 0); endfunction
  function automatic bit in_resp(); return (mdl_owner >= 0) && !mdl_wr && (mdl_sent == 1); endfunction

  always @(posedge clk) begin : model_upd
    int          w;
    logic [12:0] t;
    if (reset) begin
      mdl_owner = -1; mdl_sent = 0; mdl_recv = 0; mdl_wr = 1'b0; mdl_last = 1'b1; mdl_ok = 1'b1;
    end else if (mdl_ok) begin
      if (mdl_owner < 0) begin
        if (m0_reqcyc || m1_reqcyc) begin
          if (m0_reqcyc && m1_reqcyc) w = DPRIO ? 1 : (mdl_last ? 0 : 1);
          else                        w = m1_reqcyc ? 1 : 0;
          t = ptag(w);
          mdl_owner = w; mdl_last = (w == 1); mdl_wr = (t[11:8] == WR_CODE);
          mdl_sent = 0; mdl_recv = 0;
        end
      end else if (in_req()) begin
        if (pcyc(mdl_owner) && bus_reqack) begin
          mdl_sent++;
          if (mdl_wr && mdl_sent == BEATS + 1) mdl_owner = -1;
        end else if (!pcyc(mdl_owner) && mdl_sent == 0) begin
          mdl_owner = -1;
        end
      end else begin
        if (bus_respcyc && prack(mdl_owner)) begin
          mdl_recv++;
          if (mdl_recv == BEATS) mdl_owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit rq, rs;
    int o;
    if (mdl_ok) begin
      rq = in_req(); rs = in_resp(); o = mdl_owner;
      check("bus_reqcyc",  bus_reqcyc,  rq ? 64'(pcyc(o)) : 64'd0);
      check("bus_req",     bus_req,     rq ? preq(o) : 64'd0);
      check("bus_reqtag",  bus_reqtag,  rq ? 64'(ptag(o)) : 64'd0);
      check("m0_reqack",   m0_reqack,   (rq && o == 0) ? 64'(bus_reqack) : 64'd0);
      check("m1_reqack",   m1_reqack,   (rq && o == 1) ? 64'(bus_reqack) : 64'd0);
      check("bus_respack", bus_respack, rs ? 64'(prack(o)) : 64'd0);
      check("m0_respcyc",  m0_respcyc,  (rs && o == 0) ? 64'(bus_respcyc) : 64'd0);
      check("m0_resp",     m0_resp,     (rs && o == 0) ? bus_resp : 64'd0);
      check("m0_resptag",  m0_resptag,  (rs && o == 0) ? 64'(bus_resptag) : 64'd0);
      check("m1_respcyc",  m1_respcyc,  (rs && o == 1) ? 64'(bus_respcyc) : 64'd0);
      check("m1_resp",     m1_resp,     (rs && o == 1) ? bus_resp : 64'd0);
      check("m1_resptag",  m1_resptag,  (rs && o == 1) ? 64'(bus_resptag) : 64'd0);
    end
  end

  // Requester / bus stimulus state
  bit          rq_act[2];
  bit          rq_wr[2];
  logic [63:0] rq_addr[2];
  logic [12:0] rq_tag[2];
  int          rq_beat[2];
  int          rsp_need[2];
  int drop_pct = 0, ack_pct = 100, ack_delay = 0, resp_pct = 100, rack_pct = 100;
  int ackwait = 0, ack0_cnt = 0, m1_rc_cnt = 0;
  bit rand_mode = 1'b0;
  logic [63:0] resp_val = 64'hA0;
  logic [12:0] resp_tag = 13'h1100;
  logic [63:0] rx0[$], rx1[$], busq[$];
  logic [12:0] rxt0[$];
  int gseq[$];

  function automatic logic [63:0] beat_data(int p);
    if (rq_beat[p] == 0) return rq_addr[p];
    return 64'hD0 + 64'(rq_beat[p] - 1);
  endfunction

  function automatic bit chance(int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  task automatic start_txn(int p, bit wr, logic [63:0] addr, logic [12:0] tag);
    rq_act[p] = 1'b1; rq_wr[p] = wr; rq_addr[p] = addr; rq_tag[p] = tag; rq_beat[p] = 0;
  endtask

  task automatic clear_bfm();
    for (int p = 0; p < 2; p++) begin
      rq_act[p] = 1'b0; rq_beat[p] = 0; rsp_need[p] = 0;
    end
    ackwait = 0;
  endtask

  task automatic drive();
    m0_reqcyc = rq_act[0] && !chance(drop_pct);
    m0_req = beat_data(0); m0_reqtag = rq_tag[0];
    m1_reqcyc = rq_act[1] && !chance(drop_pct);
    m1_req = beat_data(1); m1_reqtag = rq_tag[1];
    m0_respack = chance(rack_pct);
    m1_respack = chance(rack_pct);
    bus_reqack = (ackwait >= ack_delay) && chance(ack_pct);
    bus_respcyc = chance(resp_pct);
    if (rand_mode) begin
      resp_val = {$urandom, $urandom};
      resp_tag = 13'($urandom);
    end
    bus_resp = resp_val; bus_resptag = resp_tag;
  endtask

  task automatic observe();
    for (int p = 0; p < 2; p++) begin
      if (pcyc(p) && pack(p)) begin
        if (rq_beat[p] == 0) gseq.push_back(p);
        if (p == 0) ack0_cnt++;
        rq_beat[p]++;
        if (!rq_wr[p]) begin
          rq_act[p] = 1'b0; rsp_need[p] += BEATS;
        end else if (rq_beat[p] == BEATS + 1) begin
          rq_act[p] = 1'b0;
        end
      end
    end
    if (bus_reqcyc && bus_reqack) begin busq.push_back(bus_req); ackwait = 0; end
    else if (bus_reqcyc) ackwait++;
    if (m0_respcyc && m0_respack) begin rx0.push_back(m0_resp); rxt0.push_back(m0_resptag); rsp_need[0]--; end
    if (m1_respcyc && m1_respack) begin rx1.push_back(m1_resp); rsp_need[1]--; end
    if (m1_respcyc) m1_rc_cnt++;
    if (!rand_mode && bus_respcyc && bus_respack) resp_val++;
  endtask

  task automatic step();
    drive();
    #2;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_bfm();
    step();
    reset = 1'b0;
    rx0.delete(); rx1.delete(); rxt0.delete(); busq.delete(); gseq.delete();
    ack0_cnt = 0; m1_rc_cnt = 0; ackwait = 0;
  endtask

  task automatic set_knobs(int drop, int ack, int delay, int resp, int rack);
    drop_pct = drop; ack_pct = ack; ack_delay = delay; resp_pct = resp; rack_pct = rack;
  endtask

  task automatic wait_done(string name, int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = !rq_act[0] && !rq_act[1] && rsp_need[0] <= 0 && rsp_need[1] <= 0;
    end
    step();
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    int iss[2];
    int exp4[4];
    reset = 1'b1;
    clear_bfm();
    drive();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state: both ports request, still idle for this cycle
    start_txn(0, 1'b0, 64'h1000, 13'h0000);
    start_txn(1, 1'b0, 64'h1040, 13'h0000);
    drive();
    #2;
    check("rst_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("rst_m0_reqack", 64'(m0_reqack), 64'd0);
    check("rst_m1_reqack", 64'(m1_reqack), 64'd0);
    check("rst_bus_respack", 64'(bus_respack), 64'd0);
    check("rst_m0_respcyc", 64'(m0_respcyc), 64'd0);
    @(posedge clk);
    #1;

    // Port 0 read, delayed request ack, 8 response beats
    do_reset();
    set_knobs(0, 100, 2, 100, 100);
    resp_val = 64'hA0; resp_tag = 13'h1100;
    start_txn(0, 1'b0, 64'h1000, 13'h1000);
    wait_done("t1", 100);
    check("t1_ack_pulses", 64'(ack0_cnt), 64'd1);
    check("t1_rx_count", 64'(rx0.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("t1_rx_data", (i < rx0.size()) ? rx0[i] : 64'hDEAD, 64'hA0 + 64'(i));
      check("t1_rx_tag", (i < rxt0.size()) ? 64'(rxt0[i]) : 64'hDEAD, 64'h1100);
    end
    check("t1_m1_respcyc", 64'(m1_rc_cnt), 64'd0);

    // Simultaneous reads after reset
    do_reset();
    set_knobs(0, 100, 0, 100, 100);
    start_txn(0, 1'b0, 64'h3000, 13'h0042);
    start_txn(1, 1'b0, 64'h4000, 13'h0043);
    wait_done("t2", 200);
    check("t2_grants", 64'(gseq.size()), 64'd2);
    check("t2_first", (gseq.size() > 0) ? 64'(gseq[0]) : 64'hF, DPRIO ? 64'd1 : 64'd0);
    check("t2_second", (gseq.size() > 1) ? 64'(gseq[1]) : 64'hF, DPRIO ? 64'd0 : 64'd1);

    // Port 1 write while port 0 waits
    do_reset();
    set_knobs(0, 100, 0, 100, 100);
    start_txn(1, 1'b1, 64'h2000, {1'b0, WR_CODE, 8'h07});
    step();
    start_txn(0, 1'b0, 64'h5000, 13'h0011);
    wait_done("t3", 200);
    check("t3_bus_beats", 64'(busq.size()), 64'd10);
    check("t3_addr", (busq.size() > 0) ? busq[0] : 64'hDEAD, 64'h2000);
    for (int i = 0; i < 8; i++)
      check("t3_wdata", (i + 1 < busq.size()) ? busq[i+1] : 64'hDEAD, 64'hD0 + 64'(i));
    check("t3_p0_addr", (busq.size() > 9) ? busq[9] : 64'hDEAD, 64'h5000);
    check("t3_order", (gseq.size() > 0) ? 64'(gseq[0]) : 64'hF, 64'd1);
    check("t3_m1_resp", 64'(rx1.size()), 64'd0);

    // Continuous requests, two reads per port
    do_reset();
    set_knobs(0, 100, 0, 100, 100);
    iss[0] = 0; iss[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        if (!rq_act[p] && iss[p] < 2) begin
          start_txn(p, 1'b0, 64'h6000 + 64'(p * 256 + iss[p] * 64), 13'(16 + p));
          iss[p]++;
        end
      step();
      if (iss[0] == 2 && iss[1] == 2 && !rq_act[0] && !rq_act[1] && rsp_need[0] <= 0 && rsp_need[1] <= 0) break;
    end
    if (DPRIO) exp4 = '{1, 1, 0, 0};
    else       exp4 = '{0, 1, 0, 1};
    check("t4_grants", 64'(gseq.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("t4_seq", (i < gseq.size()) ? 64'(gseq[i]) : 64'hF, 64'(exp4[i]));

    // Reset in the middle of the response phase
    do_reset();
    set_knobs(0, 100, 0, 100, 100);
    resp_val = 64'hA0;
    start_txn(0, 1'b0, 64'h7000, 13'h0055);
    for (int c = 0; c < 100 && rx0.size() < 3; c++) step();
    check("t5_reached_beat3", 64'(rx0.size()), 64'd3);
    reset = 1'b1;
    clear_bfm();
    step();
    reset = 1'b0;
    drive();
    #2;
    check("t5_m0_respcyc", 64'(m0_respcyc), 64'd0);
    check("t5_m0_resp", m0_resp, 64'd0);
    check("t5_bus_respack", 64'(bus_respack), 64'd0);
    check("t5_bus_reqcyc", 64'(bus_reqcyc), 64'd0);
    observe();
    @(posedge clk);
    #1;
    rx1.delete();
    resp_val = 64'hB0;
    start_txn(1, 1'b0, 64'h8000, 13'h0066);
    wait_done("t5", 100);
    check("t5_p1_beats", 64'(rx1.size()), 64'd8);
    check("t5_p1_first", (rx1.size() > 0) ? rx1[0] : 64'hDEAD, 64'hB0);
    check("t5_p1_last", (rx1.size() > 7) ? rx1[7] : 64'hDEAD, 64'hB7);

    // Owner abandons before its first ack
    do_reset();
    set_knobs(0, 0, 0, 100, 100);
    start_txn(0, 1'b0, 64'h9000, 13'h0077);
    step();
    start_txn(1, 1'b0, 64'hA000, 13'h0078);
    step();
    step();
    rq_act[0] = 1'b0;
    ack_pct = 100;
    wait_done("t6", 100);
    check("t6_m0_acks", 64'(ack0_cnt), 64'd0);
    check("t6_grants", 64'(gseq.size()), 64'd1);
    check("t6_owner", (gseq.size() > 0) ? 64'(gseq[0]) : 64'hF, 64'd1);

    // Random traffic against the model
    do_reset();
    rand_mode = 1'b1;
    set_knobs(10, 60, 0, 70, 70);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) < 5) begin
        reset = 1'b1;
        clear_bfm();
        step();
        reset = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++)
          if (!rq_act[p] && chance(30)) begin
            logic [3:0] nib;
            bit wr;
            wr = chance(40);
            nib = wr ? WR_CODE : 4'($urandom_range(2, 15));
            start_txn(p, wr, {$urandom, $urandom}, {1'($urandom), nib, 8'($urandom)});
          end
        step();
      end
      if (rx0.size() > 1000) begin rx0.delete(); rxt0.delete(); end
      if (rx1.size() > 1000) rx1.delete();
      if (busq.size() > 1000) busq.delete();
      if (gseq.size() > 1000) gseq.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
